// File: rtl/bitcoin_pkg.sv
// Shared types and defaults for the hasher and the result scanner.
package bitcoin_pkg;

  localparam int unsigned NUM_NONCES_DEF = 16;
  localparam int unsigned NONCE_W_DEF    = 8;
  localparam int unsigned ADDR_W         = 16;
  localparam int unsigned WORD_W         = 32;

  localparam logic [WORD_W-1:0] HASH_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_e;

endpackage

// File: rtl/hash_result_scan_if.sv
// Memory read bus between the result scanner (master) and the result RAM (slave).
//   mem_clk       : memory clock (master copy of the system clock)
//   mem_we        : write enable, always 0 from the scanner
//   mem_addr      : read address
//   mem_read_data : read data, valid two edges after its address is registered
interface hash_result_scan_if;
  import bitcoin_pkg::*;

  logic              mem_clk;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_read_data;

  modport master (
    output mem_clk,
    output mem_we,
    output mem_addr,
    input  mem_read_data
  );

  modport slave (
    input  mem_clk,
    input  mem_we,
    input  mem_addr,
    output mem_read_data
  );

endinterface

// File: rtl/hash_min_track.sv
// Tracks the minimum result word and whether any word fell below the target.
//   clk, reset  : clock, asynchronous active-high reset
//   clear       : new scan accepted; latch target and reinitialise results
//   target      : threshold, latched on clear
//   word_valid  : word_data/word_idx carry a result word this cycle
//   word_idx    : index of the word
//   word_data   : result word
//   found       : some word was strictly below the latched target
//   best_nonce  : index of the minimum word (lowest index on ties)
//   best_hash   : value of the minimum word
module hash_min_track
  import bitcoin_pkg::*;
#(
  parameter int unsigned NONCE_W = NONCE_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic [WORD_W-1:0]  target,
  input  logic               word_valid,
  input  logic [NONCE_W-1:0] word_idx,
  input  logic [WORD_W-1:0]  word_data,
  output logic               found,
  output logic [NONCE_W-1:0] best_nonce,
  output logic [WORD_W-1:0]  best_hash
);

  logic [WORD_W-1:0] target_q;

  // Strict less-than keeps the earlier index on equal words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target_q   <= '0;
      found      <= 1'b0;
      best_nonce <= '0;
      best_hash  <= HASH_MAX;
    end else if (clear) begin
      target_q   <= target;
      found      <= 1'b0;
      best_nonce <= '0;
      best_hash  <= HASH_MAX;
    end else if (word_valid) begin
      if (word_data < best_hash) begin
        best_hash  <= word_data;
        best_nonce <= word_idx;
      end
      if (word_data < target_q) begin
        found <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hash_result_scan.sv
// Scans NUM_NONCES consecutive hash result words in memory, reporting the
// minimum word, its index, and whether any word is below a target.
//   clk, reset  : clock, asynchronous active-high reset
//   start       : begin a scan (accepted only in IDLE)
//   input_addr  : base address of the result words
//   target      : unsigned threshold, latched when start is accepted
//   mem_if      : memory read bus (master)
//   done        : one-cycle pulse when results are final
//   found       : some word was below target
//   best_nonce  : index of the minimum word
//   best_hash   : value of the minimum word
module hash_result_scan
  import bitcoin_pkg::*;
#(
  parameter int unsigned NUM_NONCES = NUM_NONCES_DEF,
  parameter int unsigned NONCE_W    = NONCE_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   input_addr,
  input  logic [WORD_W-1:0]   target,
  hash_result_scan_if.master  mem_if,
  output logic                done,
  output logic                found,
  output logic [NONCE_W-1:0]  best_nonce,
  output logic [WORD_W-1:0]   best_hash
);

  localparam int unsigned      CNT_W    = $clog2(NUM_NONCES + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_NONCES - 1);

  scan_state_e        state;
  logic [CNT_W-1:0]   cnt;
  logic               vld1;
  logic               vld2;
  logic [NONCE_W-1:0] idx1;
  logic [NONCE_W-1:0] idx2;
  logic               start_acc_c;

  assign mem_if.mem_clk = clk;
  assign mem_if.mem_we  = 1'b0;
  assign start_acc_c    = (state == IDLE) && start;

  // Address issue, two-deep valid/index pipeline matching memory latency, FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      mem_if.mem_addr <= '0;
      vld1            <= 1'b0;
      vld2            <= 1'b0;
      idx1            <= '0;
      idx2            <= '0;
      done            <= 1'b0;
    end else begin
      done <= 1'b0;
      vld1 <= 1'b0;
      vld2 <= vld1;
      idx2 <= idx1;
      case (state)
        IDLE: begin
          if (start) begin
            mem_if.mem_addr <= input_addr;
            vld1            <= 1'b1;
            idx1            <= '0;
            cnt             <= CNT_W'(1);
            state           <= (NUM_NONCES == 1) ? DRAIN : SCAN;
          end
        end
        SCAN: begin
          mem_if.mem_addr <= mem_if.mem_addr + ADDR_W'(1);
          vld1            <= 1'b1;
          idx1            <= NONCE_W'(cnt);
          cnt             <= cnt + CNT_W'(1);
          if (cnt == LAST_IDX) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // Pipeline empty means the last word has been compared.
          if (!vld1 && !vld2) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  hash_min_track #(
    .NONCE_W (NONCE_W)
  ) u_min_track (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_acc_c),
    .target     (target),
    .word_valid (vld2),
    .word_idx   (idx2),
    .word_data  (mem_if.mem_read_data),
    .found      (found),
    .best_nonce (best_nonce),
    .best_hash  (best_hash)
  );

endmodule
